// File: rtl/vector_exec_issuer.sv
// ============================================================================
// Module      : vector_exec_issuer
// Description : Issues one vector ALU op to the VFU, tracks its status until
//               FINISHED, merges the result into old vd under mask/tail rules
//               and presents a single writeback beat to the register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_exec_issuer #(
    parameter int LEN              = 32,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3,
    parameter int REG_INDEX_WIDTH  = 5,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    // issue side
    input  logic                            issue_valid,
    output logic                            issue_ready,
    input  logic [2:0]                      in_vsew,
    input  logic                            in_vm,
    input  logic [ENTRY_INDEX_SIZE:0]       in_length,
    input  logic [VECTOR_SIZE*LEN-1:0]      in_vs1,
    input  logic [VECTOR_SIZE*LEN-1:0]      in_vs2,
    input  logic [VECTOR_SIZE*LEN-1:0]      in_mask,
    input  logic [VECTOR_SIZE*LEN-1:0]      in_old_vd,
    input  logic [LEN-1:0]                  in_imm,
    input  logic [LEN-1:0]                  in_rs,
    input  logic [2:0]                      in_alu_signal,
    input  logic [1:0]                      in_operand_type,
    input  logic [4:0]                      in_ext_type,
    input  logic [5:0]                      in_funct6,
    input  logic [REG_INDEX_WIDTH-1:0]      in_vd,
    // VFU side
    output logic                            execute,
    output logic [2:0]                      vsew,
    output logic                            vm,
    output logic [ENTRY_INDEX_SIZE:0]       length,
    output logic [VECTOR_SIZE*LEN-1:0]      vs1,
    output logic [VECTOR_SIZE*LEN-1:0]      vs2,
    output logic [VECTOR_SIZE*LEN-1:0]      mask,
    output logic [LEN-1:0]                  imm,
    output logic [LEN-1:0]                  rs,
    output logic [2:0]                      alu_signal,
    output logic [1:0]                      vec_operand_type,
    output logic [4:0]                      ext_type,
    output logic [5:0]                      funct6,
    input  logic [VECTOR_SIZE*LEN-1:0]      vfu_result,
    input  logic [1:0]                      vfu_status,
    // writeback side
    output logic                            wb_valid,
    input  logic                            wb_ready,
    output logic [REG_INDEX_WIDTH-1:0]      wb_vd,
    output logic [VECTOR_SIZE*LEN-1:0]      wb_data,
    output logic                            busy,
    output logic                            timeout_err
);

    localparam int c_vec_w  = VECTOR_SIZE * LEN;
    localparam int c_nbytes = c_vec_w / 8;
    localparam int c_cnt_w  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [1:0] c_status_working  = 2'b01;
    localparam logic [1:0] c_status_finished = 2'b10;

    localparam logic [2:0] c_sew_8  = 3'd0;
    localparam logic [2:0] c_sew_16 = 3'd1;
    localparam logic [2:0] c_sew_32 = 3'd2;
    localparam logic [2:0] c_sew_64 = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t                       r_state;
    state_t                       w_state_next;
    logic                         w_execute;
    logic                         w_capture;
    logic                         w_timeout;
    logic                         w_issue_ready;

    logic [2:0]                   r_vsew;
    logic                         r_vm;
    logic [ENTRY_INDEX_SIZE:0]    r_length;
    logic [c_vec_w-1:0]           r_vs1;
    logic [c_vec_w-1:0]           r_vs2;
    logic [c_vec_w-1:0]           r_mask;
    logic [c_vec_w-1:0]           r_old_vd;
    logic [LEN-1:0]               r_imm;
    logic [LEN-1:0]               r_rs;
    logic [2:0]                   r_alu_signal;
    logic [1:0]                   r_operand_type;
    logic [4:0]                   r_ext_type;
    logic [5:0]                   r_funct6;
    logic [REG_INDEX_WIDTH-1:0]   r_vd;
    logic [c_vec_w-1:0]           r_wb_data;
    logic                         r_seen_working;
    logic [c_cnt_w-1:0]           r_wait_cnt;
    logic                         r_timeout_err;
    logic [c_vec_w-1:0]           w_merge;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_execute     = 1'b0;
        w_capture     = 1'b0;
        w_timeout     = 1'b0;
        w_issue_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_issue_ready = 1'b1;
                if (issue_valid) begin
                    w_state_next = (in_length == '0) ? S_WB : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // Never launch on top of an op the VFU is still working on.
                if (vfu_status != c_status_working) begin
                    w_execute    = 1'b1;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (vfu_status == c_status_finished && r_seen_working) begin
                    w_capture    = 1'b1;
                    w_state_next = S_WB;
                end else if (r_wait_cnt == c_cnt_last) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_WB;
                end
            end
            S_WB: begin
                if (wb_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand hold, status tracking and writeback data
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vsew         <= '0;
            r_vm           <= 1'b0;
            r_length       <= '0;
            r_vs1          <= '0;
            r_vs2          <= '0;
            r_mask         <= '0;
            r_old_vd       <= '0;
            r_imm          <= '0;
            r_rs           <= '0;
            r_alu_signal   <= '0;
            r_operand_type <= '0;
            r_ext_type     <= '0;
            r_funct6       <= '0;
            r_vd           <= '0;
            r_wb_data      <= '0;
            r_seen_working <= 1'b0;
            r_wait_cnt     <= '0;
            r_timeout_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (issue_valid) begin
                        r_vsew         <= in_vsew;
                        r_vm           <= in_vm;
                        r_length       <= in_length;
                        r_vs1          <= in_vs1;
                        r_vs2          <= in_vs2;
                        r_mask         <= in_mask;
                        r_old_vd       <= in_old_vd;
                        r_imm          <= in_imm;
                        r_rs           <= in_rs;
                        r_alu_signal   <= in_alu_signal;
                        r_operand_type <= in_operand_type;
                        r_ext_type     <= in_ext_type;
                        r_funct6       <= in_funct6;
                        r_vd           <= in_vd;
                        // Preloading old vd covers both the zero-length and the timeout writeback.
                        r_wb_data      <= in_old_vd;
                    end
                end
                S_LAUNCH: begin
                    r_seen_working <= 1'b0;
                    r_wait_cnt     <= '0;
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + c_cnt_one;
                    if (vfu_status == c_status_working) begin
                        r_seen_working <= 1'b1;
                    end
                    if (w_capture) begin
                        r_wb_data <= w_merge;
                    end
                    if (w_timeout) begin
                        r_timeout_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Mask/tail merge, resolved per byte: each byte belongs to element
    // byte/(w/8) for every supported element width.
    // ------------------------------------------------------------------
    for (genvar b = 0; b < c_nbytes; b++) begin : g_byte
        localparam int unsigned c_e8  = b;
        localparam int unsigned c_e16 = b / 2;
        localparam int unsigned c_e32 = b / 4;
        localparam int unsigned c_e64 = b / 8;
        localparam bit c_x16 = ((c_e16 + 1) * 2) <= c_nbytes;
        localparam bit c_x32 = ((c_e32 + 1) * 4) <= c_nbytes;
        localparam bit c_x64 = ((c_e64 + 1) * 8) <= c_nbytes;

        logic w_active;

        always_comb begin
            w_active = 1'b0;
            case (r_vsew)
                c_sew_8:  w_active = (32'(r_length) > c_e8)  && (r_vm || r_mask[c_e8]);
                c_sew_16: w_active = c_x16 && (32'(r_length) > c_e16) && (r_vm || r_mask[c_e16]);
                c_sew_32: w_active = c_x32 && (32'(r_length) > c_e32) && (r_vm || r_mask[c_e32]);
                c_sew_64: w_active = c_x64 && (32'(r_length) > c_e64) && (r_vm || r_mask[c_e64]);
                default:  w_active = 1'b0;
            endcase
        end

        assign w_merge[8*b +: 8] = w_active ? vfu_result[8*b +: 8] : r_old_vd[8*b +: 8];
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign issue_ready      = w_issue_ready;
    assign execute          = w_execute;
    assign vsew             = r_vsew;
    assign vm               = r_vm;
    assign length           = r_length;
    assign vs1              = r_vs1;
    assign vs2              = r_vs2;
    assign mask             = r_mask;
    assign imm              = r_imm;
    assign rs               = r_rs;
    assign alu_signal       = r_alu_signal;
    assign vec_operand_type = r_operand_type;
    assign ext_type         = r_ext_type;
    assign funct6           = r_funct6;
    assign wb_valid         = (r_state == S_WB);
    assign wb_vd            = r_vd;
    assign wb_data          = r_wb_data;
    assign busy             = (r_state != S_IDLE);
    assign timeout_err      = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_vector_exec_issuer.sv
// ============================================================================
// Module      : tb_vector_exec_issuer
// Description : Self-checking bench for vector_exec_issuer with a behavioural
//               VFU (two lanes per cycle) and an element-level merge model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vector_exec_issuer;

    localparam int VW       = 256;
    localparam int TIMEOUT  = 64;
    localparam logic [1:0] ST_NOP      = 2'b00;
    localparam logic [1:0] ST_WORKING  = 2'b01;
    localparam logic [1:0] ST_FINISHED = 2'b10;
    localparam logic [5:0] V_ADD = 6'b000000;

    typedef struct {
        logic [2:0]    vsew;
        logic          vm;
        logic [3:0]    length;
        logic [VW-1:0] mask;
        logic [VW-1:0] vs1;
        logic [VW-1:0] vs2;
        logic [VW-1:0] old_vd;
        logic [31:0]   imm;
        logic [31:0]   rs;
        logic [2:0]    alu;
        logic [1:0]    optype;
        logic [4:0]    ext;
        logic [5:0]    funct6;
        logic [4:0]    vd;
    } op_t;

    typedef struct {
        op_t           op;
        int            wb_delay;
        logic [VW-1:0] exp_data;
        int            exp_exec;
    } vec_t;

    logic clk, rst;
    logic issue_valid, issue_ready;
    logic [2:0] in_vsew;
    logic in_vm;
    logic [3:0] in_length;
    logic [VW-1:0] in_vs1, in_vs2, in_mask, in_old_vd;
    logic [31:0] in_imm, in_rs;
    logic [2:0] in_alu_signal;
    logic [1:0] in_operand_type;
    logic [4:0] in_ext_type;
    logic [5:0] in_funct6;
    logic [4:0] in_vd;
    logic execute;
    logic [2:0] vsew;
    logic vm;
    logic [3:0] length;
    logic [VW-1:0] vs1, vs2, mask;
    logic [31:0] imm, rs;
    logic [2:0] alu_signal;
    logic [1:0] vec_operand_type;
    logic [4:0] ext_type;
    logic [5:0] funct6;
    logic [VW-1:0] vfu_result;
    logic [1:0] vfu_status;
    logic wb_valid, wb_ready;
    logic [4:0] wb_vd;
    logic [VW-1:0] wb_data;
    logic busy, timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    vector_exec_issuer dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .in_vsew(in_vsew), .in_vm(in_vm), .in_length(in_length),
        .in_vs1(in_vs1), .in_vs2(in_vs2), .in_mask(in_mask), .in_old_vd(in_old_vd),
        .in_imm(in_imm), .in_rs(in_rs), .in_alu_signal(in_alu_signal),
        .in_operand_type(in_operand_type), .in_ext_type(in_ext_type),
        .in_funct6(in_funct6), .in_vd(in_vd),
        .execute(execute), .vsew(vsew), .vm(vm), .length(length),
        .vs1(vs1), .vs2(vs2), .mask(mask), .imm(imm), .rs(rs),
        .alu_signal(alu_signal), .vec_operand_type(vec_operand_type),
        .ext_type(ext_type), .funct6(funct6),
        .vfu_result(vfu_result), .vfu_status(vfu_status),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_vd(wb_vd), .wb_data(wb_data),
        .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference functions ----------------
    function automatic int sew_bits(input logic [2:0] s);
        case (s)
            3'd0: return 8;
            3'd1: return 16;
            3'd2: return 32;
            3'd3: return 64;
            default: return 0;
        endcase
    endfunction

    function automatic logic [VW-1:0] vadd(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                           input logic [2:0] s);
        logic [VW-1:0] r = '0;
        int w = sew_bits(s);
        if (w == 0) return r;
        for (int e = 0; e < VW / w; e++) begin
            logic [63:0] x = 64'(a >> (e * w));
            logic [63:0] y = 64'(b >> (e * w));
            logic [63:0] m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
            logic [63:0] z = (x + y) & m;
            r = r | (VW'(z) << (e * w));
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] ref_merge(input op_t op, input logic [VW-1:0] res);
        logic [VW-1:0] r = op.old_vd;
        int w = sew_bits(op.vsew);
        if (w == 0) return r;
        for (int e = 0; e < VW / w; e++)
            if (e < int'(op.length) && (op.vm || op.mask[e]))
                for (int k = 0; k < w; k++) r[e*w + k] = res[e*w + k];
        return r;
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] r;
        for (int i = 0; i < VW / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic op_t mk_op(input logic [2:0] s, input logic v, input logic [3:0] len,
                                  input logic [VW-1:0] m, input logic [VW-1:0] a,
                                  input logic [VW-1:0] b, input logic [VW-1:0] old,
                                  input logic [4:0] vd);
        op_t o;
        o.vsew = s; o.vm = v; o.length = len; o.mask = m; o.vs1 = a; o.vs2 = b;
        o.old_vd = old; o.imm = 32'h0000_0011; o.rs = 32'h0000_0022; o.alu = 3'd1;
        o.optype = 2'd0; o.ext = 5'd0; o.funct6 = V_ADD; o.vd = vd;
        return o;
    endfunction

    // ---------------- behavioural VFU ----------------
    bit   vfu_stuck = 0;
    int   vfu_start_delay = 0;
    logic [VW-1:0] vfu_pending;
    int   vfu_cnt, vfu_dly;
    bit   vfu_pend_start;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            vfu_status <= ST_NOP; vfu_result <= '0; vfu_pending <= '0;
            vfu_cnt <= 0; vfu_dly <= 0; vfu_pend_start <= 0;
        end else if (execute) begin
            vfu_pending <= vadd(vs1, vs2, vsew);
            vfu_cnt     <= (int'(length) + 1) / 2 - 1;
            vfu_dly     <= vfu_start_delay;
            if (vfu_start_delay == 0) vfu_status <= ST_WORKING;
            else vfu_pend_start <= 1;
        end else if (vfu_pend_start) begin
            if (vfu_dly <= 1) begin vfu_status <= ST_WORKING; vfu_pend_start <= 0; end
            vfu_dly <= vfu_dly - 1;
        end else if (vfu_status == ST_WORKING && !vfu_stuck) begin
            if (vfu_cnt == 0) begin vfu_status <= ST_FINISHED; vfu_result <= vfu_pending; end
            else vfu_cnt <= vfu_cnt - 1;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input op_t op, input int wb_delay, input logic [VW-1:0] exp_data,
                          input int exp_exec, output int lat);
        int exec_seen = 0;
        bit got = 0;
        int cyc;
        lat = -1;
        @(negedge clk);
        chk("issue_ready_idle", issue_ready, 1'b1);
        issue_valid = 1; in_vsew = op.vsew; in_vm = op.vm; in_length = op.length;
        in_vs1 = op.vs1; in_vs2 = op.vs2; in_mask = op.mask; in_old_vd = op.old_vd;
        in_imm = op.imm; in_rs = op.rs; in_alu_signal = op.alu; in_operand_type = op.optype;
        in_ext_type = op.ext; in_funct6 = op.funct6; in_vd = op.vd;
        @(negedge clk);
        issue_valid = 0;
        in_vs1 = '0; in_vs2 = '0; in_funct6 = 6'h3f;
        for (cyc = 0; cyc < 200; cyc++) begin
            if (execute) begin
                exec_seen++;
                lat = 0;
                chk("held_vs1", vs1, op.vs1);
                chk("held_fields", {mask[63:0], imm, rs, funct6, length, vsew},
                    {op.mask[63:0], op.imm, op.rs, op.funct6, op.length, op.vsew});
            end
            if (wb_valid) begin got = 1; break; end
            @(negedge clk);
            if (lat >= 0) lat++;
        end
        chk("wb_reached", got, 1'b1);
        chk("exec_count", exec_seen, exp_exec);
        if (op.length == 0) chk("len0_wb_latency", cyc, 0);
        for (int k = 0; k < wb_delay; k++) begin
            chk("wb_hold", {wb_valid, issue_ready, busy, wb_data}, {1'b1, 1'b0, 1'b1, exp_data});
            @(negedge clk);
        end
        chk("wb_data", wb_data, exp_data);
        chk("wb_vd", wb_vd, op.vd);
        wb_ready = 1;
        @(negedge clk);
        wb_ready = 0;
        chk("wb_drop", {wb_valid, busy}, 2'b00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        localparam logic [VW-1:0] SLOTS = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        localparam logic [VW-1:0] OLD = {32'hA000_0007, 32'hA000_0006, 32'hA000_0005, 32'hA000_0004,
                                         32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        localparam logic [VW-1:0] UP4 = {32'hA000_0007, 32'hA000_0006, 32'hA000_0005, 32'hA000_0004};
        vec_t tbl[9];
        op_t  op, op_b;
        int   lat;
        logic [VW-1:0] exp;

        rst = 0; issue_valid = 0; wb_ready = 0;
        in_vsew = '0; in_vm = 0; in_length = '0; in_vs1 = '0; in_vs2 = '0; in_mask = '0;
        in_old_vd = '0; in_imm = '0; in_rs = '0; in_alu_signal = '0; in_operand_type = '0;
        in_ext_type = '0; in_funct6 = '0; in_vd = '0;

        repeat (2) @(negedge clk);
        chk("rst_ctrl", {issue_ready, busy, execute, wb_valid, timeout_err}, 5'b10000);
        chk("rst_wb_data", wb_data, '0);
        chk("rst_held", {vs1[31:0], wb_vd, length, funct6}, '0);
        rst = 1;

        tbl[0] = '{mk_op(3'd2, 1, 4'd4, '0, SLOTS, SLOTS, OLD, 5'd3), 0,
                   {UP4, 32'd8, 32'd6, 32'd4, 32'd2}, 1};
        tbl[1] = '{mk_op(3'd2, 0, 4'd4, VW'(4'b0101), SLOTS, SLOTS, OLD, 5'd4), 0,
                   {UP4, 32'hA000_0003, 32'd6, 32'hA000_0001, 32'd2}, 1};
        tbl[2] = '{mk_op(3'd2, 1, 4'd0, '0, SLOTS, SLOTS, OLD, 5'd5), 0, OLD, 0};
        tbl[3] = '{mk_op(3'd2, 1, 4'd4, '0, SLOTS, SLOTS, OLD, 5'd6), 5,
                   {UP4, 32'd8, 32'd6, 32'd4, 32'd2}, 1};
        tbl[4] = '{mk_op(3'd0, 1, 4'd5, '0, SLOTS, SLOTS, OLD, 5'd7), 0,
                   {UP4, 32'hA000_0003, 32'hA000_0002, 32'hA000_0004, 32'h0000_0002}, 1};
        tbl[5] = '{mk_op(3'd3, 1, 4'd3, '0, SLOTS, SLOTS, OLD, 5'd8), 0,
                   {32'hA000_0007, 32'hA000_0006, 32'd12, 32'd10, 32'd8, 32'd6, 32'd4, 32'd2}, 1};
        tbl[6] = '{mk_op(3'd2, 1, 4'd15, '0, SLOTS, SLOTS, OLD, 5'd9), 0,
                   {32'd16, 32'd14, 32'd12, 32'd10, 32'd8, 32'd6, 32'd4, 32'd2}, 1};
        tbl[7] = '{mk_op(3'd7, 1, 4'd4, '0, SLOTS, SLOTS, OLD, 5'd10), 0, OLD, 1};
        tbl[8] = '{mk_op(3'd1, 0, 4'd3, VW'(3'b110), SLOTS, SLOTS, OLD, 5'd11), 0,
                   {UP4, 32'hA000_0003, 32'hA000_0002, 32'hA000_0004, 32'h0000_0000}, 1};

        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].op, tbl[i].wb_delay, tbl[i].exp_data, tbl[i].exp_exec, lat);
            if (i == 0) chk("first_op_latency", lat, 4);
        end
        chk("no_timeout_yet", timeout_err, 1'b0);

        // Back-to-back: second op launches while the VFU still shows FINISHED.
        op = mk_op(3'd2, 1, 4'd8, '0, rnd_vec(), rnd_vec(), rnd_vec(), 5'd12);
        run_op(op, 0, ref_merge(op, vadd(op.vs1, op.vs2, op.vsew)), 1, lat);
        op_b = mk_op(3'd2, 1, 4'd8, '0, rnd_vec(), rnd_vec(), rnd_vec(), 5'd13);
        vfu_start_delay = 3;
        run_op(op_b, 0, ref_merge(op_b, vadd(op_b.vs1, op_b.vs2, op_b.vsew)), 1, lat);
        vfu_start_delay = 0;

        for (int i = 0; i < 40; i++) begin
            op = mk_op(($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 3)),
                       1'($urandom), 4'($urandom_range(0, 15)), rnd_vec(), rnd_vec(),
                       rnd_vec(), rnd_vec(), 5'($urandom));
            op.imm = $urandom; op.rs = $urandom; op.funct6 = 6'($urandom);
            vfu_start_delay = $urandom_range(0, 2);
            exp = ref_merge(op, vadd(op.vs1, op.vs2, op.vsew));
            run_op(op, $urandom_range(0, 3), exp, (op.length != 0) ? 1 : 0, lat);
        end
        vfu_start_delay = 0;

        // VFU stuck in WORKING: timeout writes back old vd.
        vfu_stuck = 1;
        op = mk_op(3'd2, 1, 4'd4, '0, SLOTS, SLOTS, OLD, 5'd14);
        run_op(op, 1, OLD, 1, lat);
        chk("timeout_latency", lat, TIMEOUT + 1);
        chk("timeout_err_set", timeout_err, 1'b1);
        vfu_stuck = 0;

        // Sticky error; the VFU model is reset so the next op starts clean.
        rst = 0; #1; rst = 1;
        chk("timeout_cleared_by_reset", timeout_err, 1'b0);
        op = mk_op(3'd2, 1, 4'd2, '0, SLOTS, SLOTS, OLD, 5'd15);
        run_op(op, 0, {OLD[VW-1:64], 32'd4, 32'd2}, 1, lat);

        // Reset in the middle of WAIT.
        vfu_stuck = 1;
        @(negedge clk);
        issue_valid = 1; in_vsew = 3'd2; in_vm = 1; in_length = 4'd4; in_vs1 = SLOTS;
        in_vs2 = SLOTS; in_old_vd = OLD; in_vd = 5'd21; in_funct6 = V_ADD;
        @(negedge clk);
        issue_valid = 0;
        repeat (6) @(negedge clk);
        chk("busy_before_reset", busy, 1'b1);
        rst = 0;
        #1;
        chk("midop_rst_ctrl", {issue_ready, busy, execute, wb_valid, timeout_err}, 5'b10000);
        chk("midop_rst_data", {wb_data, vs1[31:0], wb_vd}, '0);
        @(negedge clk);
        rst = 1; vfu_stuck = 0;
        begin
            bit saw_wb = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (wb_valid) saw_wb = 1;
            end
            chk("no_wb_after_reset", saw_wb, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
